// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for dev_bus_arbiter: FSM state encodings, owner codes
// and the round-robin pick helper.
package dev_bus_arbiter_pkg;

    localparam int ARB_ST_LEN = 2;

    typedef enum logic [ARB_ST_LEN-1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_BUSY = 2'd1,
        ARB_ST_RESP = 2'd2
    } arb_state_t;

    localparam logic ARB_OWNER_M0 = 1'b0;
    localparam logic ARB_OWNER_M1 = 1'b1;

    // A lone requester always wins; on a tie the round-robin pointer decides.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic rr);
        if (req0 && req1) begin
            return rr;
        end
        return req1 ? ARB_OWNER_M1 : ARB_OWNER_M0;
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_watchdog.sv
// Device-wait watchdog for dev_bus_arbiter, only instantiated when ARB_TIMEOUT_EN is defined.
// Flags expiry in the TIMEOUT-th consecutive waiting cycle without an ack.
module arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    input  logic ack,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (tick && !ack) begin
            count <= count + 1'b1;
        end
    end

    // An ack in the final cycle takes precedence over expiry.
    assign expired = tick && !ack && (count == LAST);

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral port between two masters, one transaction in flight.
// Define ARB_TIMEOUT_EN to fail transactions the device never acknowledges.
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              dev_valid,
    output logic              dev_we,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    input  logic              dev_ack,
    input  logic [DATA_W-1:0] dev_rdata,
    output logic              owner,
    output logic              busy
);

    arb_state_t        state, state_d;
    logic              rr;
    logic              owner_q;
    logic              grant;
    logic              start;
    logic              expired;
    logic              err_resp;
    logic [DATA_W-1:0] rdata_q;

`ifdef ARB_TIMEOUT_EN
    logic err_q;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tick    (state == ARB_ST_BUSY),
        .ack     (dev_ack),
        .expired (expired)
    );

    // Only the value captured on the BUSY exit edge is ever presented.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state == ARB_ST_BUSY) begin
            err_q <= !dev_ack;
        end
    end

    assign err_resp = err_q;
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign err_resp       = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d   = state;
        start     = 1'b0;
        grant     = arb_pick(m0_req, m1_req, rr);
        dev_valid = (state == ARB_ST_BUSY);
        busy      = (state != ARB_ST_IDLE);
        m0_ready  = 1'b0;
        m0_rdata  = '0;
        m0_err    = 1'b0;
        m1_ready  = 1'b0;
        m1_rdata  = '0;
        m1_err    = 1'b0;
        case (state)
            ARB_ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ARB_ST_BUSY;
                    start   = 1'b1;
                end
            end
            ARB_ST_BUSY: begin
                if (dev_ack || expired) begin
                    state_d = ARB_ST_RESP;
                end
            end
            ARB_ST_RESP: begin
                state_d = ARB_ST_IDLE;
                if (owner_q == ARB_OWNER_M1) begin
                    m1_ready = 1'b1;
                    m1_rdata = rdata_q;
                    m1_err   = err_resp;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = rdata_q;
                    m0_err   = err_resp;
                end
            end
            default: state_d = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB_ST_IDLE;
            rr        <= ARB_OWNER_M0;
            owner_q   <= ARB_OWNER_M0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_d;
            case (state)
                ARB_ST_IDLE: begin
                    if (start) begin
                        owner_q   <= grant;
                        dev_we    <= (grant == ARB_OWNER_M1) ? m1_we    : m0_we;
                        dev_addr  <= (grant == ARB_OWNER_M1) ? m1_addr  : m0_addr;
                        dev_wdata <= (grant == ARB_OWNER_M1) ? m1_wdata : m0_wdata;
                    end
                end
                // Writes and timed-out transactions both return zero data.
                ARB_ST_BUSY: rdata_q <= (dev_ack && !dev_we) ? dev_rdata : '0;
                ARB_ST_RESP: rr <= ~owner_q;
                default: ;
            endcase
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: per-master response scoreboards, a round-robin
// reference model, directed scenarios and a randomized two-master phase.
module tb_dev_bus_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int TB_TIMEOUT = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m0_ready, m0_err, m1_ready, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              dev_valid, dev_we, dev_ack, owner, busy;
    logic [ADDR_W-1:0] dev_addr;
    logic [DATA_W-1:0] dev_wdata, dev_rdata;

    int   compared = 0;
    int   mismatched = 0;
    int   cycle = 0;
    exp_t m0_q[$];
    exp_t m1_q[$];
    logic owner_q[$];

    // Device model: dev_wait < 0 means never acknowledge
    int   dev_wait = 0;
    bit   rand_mode = 1'b0;
    int   cur_wait = 0;
    int   valid_cnt = 0;

    logic [1:0] req_at_edge = 2'b00;
    logic       rst_at_edge = 1'b0;

    dev_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dev_valid(dev_valid), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] devData(input logic [ADDR_W-1:0] a);
        return a ^ 32'h1234_297C;
    endfunction

    always @(posedge clk) begin
        cycle       <= cycle + 1;
        req_at_edge <= {m1_req, m0_req};
        rst_at_edge <= reset;
        if (!dev_valid) begin
            valid_cnt <= 0;
            cur_wait  <= rand_mode ? int'($urandom_range(0, 3)) : dev_wait;
        end else begin
            valid_cnt <= valid_cnt + 1;
        end
    end

    assign dev_ack   = dev_valid && (cur_wait >= 0) && (valid_cnt >= cur_wait);
    assign dev_rdata = dev_ack ? devData(dev_addr) : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic readyOf(input int id);
        return (id == 0) ? m0_ready : m1_ready;
    endfunction

    task automatic driveReq(input int id, input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (id == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic applyStimulus(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, output int lat);
        exp_t e;
        e.err   = TO_EN && (dev_wait < 0) && !rand_mode;
        e.rdata = (we || e.err) ? '0 : devData(addr);
        @(posedge clk);
        #1;
        if (id == 0) m0_q.push_back(e);
        else         m1_q.push_back(e);
        driveReq(id, 1'b1, we, addr, wdata);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!readyOf(id) && lat < 200);
        checkOutput("ready_seen", readyOf(id), 1'b1);
        if (id == 0) m0_req = 1'b0;
        else         m1_req = 1'b0;
    endtask

    task automatic runMaster(input int id, input int n);
        int lat;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            applyStimulus(id, 1'($urandom_range(0, 1)), {16'h7F00, 16'($urandom)}, $urandom, lat);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: reference round-robin model plus scoreboard pops on every ready
    initial begin
        logic              exp_favored = 1'b0;
        logic              prev_valid = 1'b0;
        logic              inflight = 1'b0;
        logic              cur_owner = 1'b0;
        logic              exp_win;
        logic              any_rdy;
        logic              mon_rdy [2];
        logic [DATA_W-1:0] mon_rd [2];
        logic              mon_er [2];
        exp_t              e;
        forever begin
            @(negedge clk);
            if (!rst_at_edge) begin
                exp_favored = 1'b0;
                prev_valid  = 1'b0;
                inflight    = 1'b0;
                checkOutput("reset_ctrl", {busy, dev_valid, dev_we, owner, m0_ready, m0_err,
                                           m1_ready, m1_err}, 0);
                checkOutput("reset_dev", {dev_addr, dev_wdata}, 0);
                checkOutput("reset_rdata", {m0_rdata, m1_rdata}, 0);
            end else begin
                if (dev_valid && !prev_valid) begin
                    checkOutput("grant_req", |req_at_edge, 1'b1);
                    exp_win = (req_at_edge == 2'b11) ? exp_favored : req_at_edge[1];
                    checkOutput("grant_owner", owner, exp_win);
                    if (owner_q.size() > 0) checkOutput("grant_order", owner, owner_q.pop_front());
                    cur_owner = exp_win;
                    inflight  = 1'b1;
                end
                if (dev_valid) begin
                    checkOutput("dev_port", {dev_we, dev_addr, dev_wdata},
                                cur_owner ? {m1_we, m1_addr, m1_wdata} : {m0_we, m0_addr, m0_wdata});
                end
                mon_rdy[0] = m0_ready; mon_rd[0] = m0_rdata; mon_er[0] = m0_err;
                mon_rdy[1] = m1_ready; mon_rd[1] = m1_rdata; mon_er[1] = m1_err;
                any_rdy = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (mon_rdy[i]) begin
                        any_rdy = 1'b1;
                        checkOutput("ready_owner", {inflight, cur_owner, owner}, {1'b1, 1'(i), 1'(i)});
                        if ((i == 0 && m0_q.size() == 0) || (i == 1 && m1_q.size() == 0)) begin
                            checkOutput("ready_unexpected", mon_rdy[i], 1'b0);
                        end else begin
                            if (i == 0) e = m0_q.pop_front();
                            else        e = m1_q.pop_front();
                            checkOutput("resp_rdata", mon_rd[i], e.rdata);
                            checkOutput("resp_err", mon_er[i], e.err);
                        end
                        exp_favored = ~1'(i);
                    end else begin
                        checkOutput("quiet_resp", {mon_rd[i], mon_er[i]}, 0);
                    end
                end
                if (any_rdy) inflight = 1'b0;
                checkOutput("busy", busy, dev_valid | m0_ready | m1_ready);
                prev_valid = dev_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        mismatched++;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin
        int lat, lat0, lat4, la, lb, n;
        int r_m0a, r_m0b, r_m1a, r_m1b;

        $display("[TB] reset and idle");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 checkOutput("idle_quiet", {busy, dev_valid, m0_ready, m1_ready, owner}, 0);
        end

        $display("[TB] single m0 read");
        dev_wait = 1;
        applyStimulus(0, 1'b0, 32'h7F04, 32'h0, lat);
        checkOutput("read_latency", lat, 3);

        $display("[TB] both masters held, alternating grants");
        doReset();
        dev_wait = 0;
        owner_q.push_back(1'b0); owner_q.push_back(1'b1);
        owner_q.push_back(1'b0); owner_q.push_back(1'b1);
        fork
            begin
                applyStimulus(0, 1'b1, 32'h7F00, 32'hA0A0_0001, la); r_m0a = cycle;
                applyStimulus(0, 1'b1, 32'h7F00, 32'hA0A0_0002, la); r_m0b = cycle;
            end
            begin
                applyStimulus(1, 1'b1, 32'h7F10, 32'hB1B1_0001, lb); r_m1a = cycle;
                applyStimulus(1, 1'b1, 32'h7F10, 32'hB1B1_0002, lb); r_m1b = cycle;
            end
        join
        checkOutput("rr_spacing_m1a", r_m1a - r_m0a, 3);
        checkOutput("rr_spacing_m0b", r_m0b - r_m0a, 6);
        checkOutput("rr_spacing_m1b", r_m1b - r_m0b, 3);
        checkOutput("rr_order_drained", owner_q.size(), 0);

        $display("[TB] device wait states");
        dev_wait = 0;
        applyStimulus(1, 1'b0, 32'h7F08, 32'h0, lat0);
        dev_wait = 4;
        applyStimulus(1, 1'b0, 32'h7F08, 32'h0, lat4);
        checkOutput("zero_wait_latency", lat0, 2);
        checkOutput("wait_latency_delta", lat4 - lat0, 4);

        $display("[TB] unacknowledged transaction");
        dev_wait = -1;
`ifdef ARB_TIMEOUT_EN
        applyStimulus(0, 1'b0, 32'h7F20, 32'h0, lat);
        checkOutput("timeout_latency", lat, TB_TIMEOUT + 1);
        dev_wait = 0;
        applyStimulus(0, 1'b0, 32'h7F24, 32'h0, lat);
        checkOutput("after_timeout_latency", lat, 2);
`else
        @(posedge clk);
        #1 driveReq(0, 1'b1, 1'b0, 32'h7F20, 32'h0);
        repeat (40) @(posedge clk);
        #1 checkOutput("stall_busy", {busy, dev_valid, m0_ready}, 3'b110);
        m0_req = 1'b0;
        doReset();
        dev_wait = 0;
`endif

        $display("[TB] reset during a device wait");
        doReset();
        dev_wait = 0;
        applyStimulus(0, 1'b1, 32'h7F2C, 32'hCAFE_0001, lat);
        dev_wait = 10;
        @(posedge clk);
        #1 driveReq(1, 1'b1, 1'b0, 32'h7F30, 32'h0);
        n = 0;
        while (!dev_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("abort_granted", dev_valid, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        checkOutput("abort_quiet", {dev_valid, busy, m1_ready}, 0);
        dev_wait = 0;
        owner_q.push_back(1'b0); owner_q.push_back(1'b1);
        fork
            applyStimulus(0, 1'b0, 32'h7F34, 32'h0, la);
            applyStimulus(1, 1'b0, 32'h7F38, 32'h0, lb);
        join
        checkOutput("abort_order_drained", owner_q.size(), 0);

        $display("[TB] randomized traffic");
        rand_mode = 1'b1;
        fork
            runMaster(0, 30);
            runMaster(1, 30);
        join
        rand_mode = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("m0_scoreboard_drained", m0_q.size(), 0);
        checkOutput("m1_scoreboard_drained", m1_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
